// File: rtl/data_memory_uart_dump.sv
// data_memory_uart_dump: word-addressed data memory with byte lanes and an 8N1 UART dump port
//  clk, rst                 : clock, synchronous active-high reset
//  writeEn, byteEn, dataIn  : lane-masked write to mem[address]
//  readEn, dataOut          : registered read of mem[address] (0 when out of range)
//  address                  : word index, valid below DEPTH
//  enableUart               : rising edge starts a dump of words 0..DUMP_WORDS-1
//  dataUart                 : UART TX line, idle high, LSB-first bytes, LSB-first words
//  uartBusy, uartDone       : dump in progress / one-cycle completion pulse
module data_memory_uart_dump #(
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 64,
   parameter int DUMP_WORDS   = DEPTH,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                writeEn,
   input  logic                readEn,
   input  logic [DATA_W/8-1:0] byteEn,
   input  logic [31:0]         address,
   input  logic [DATA_W-1:0]   dataIn,
   output logic [DATA_W-1:0]   dataOut,
   input  logic                enableUart,
   output logic                dataUart,
   output logic                uartBusy,
   output logic                uartDone
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int NB = DATA_W / 8;
   localparam int BW = NB > 1 ? $clog2(NB) : 1;
   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, DONE} uartStateT;

   uartStateT         state, nextState;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] shreg;
   logic [CW-1:0]     baudCnt;
   logic [2:0]        bitIdx;
   logic [BW-1:0]     byteIdx;
   logic [AW-1:0]     wordIdx;
   logic              enPrev;
   logic              addrOk, trigger, baudTick, lastBit, lastByte, lastWord;
   logic [AW-1:0]     addrIdx;

   assign addrOk   = address < 32'(DEPTH);
   assign addrIdx  = address[AW-1:0];
   assign trigger  = enableUart & ~enPrev;
   assign baudTick = baudCnt == CW'(CLKS_PER_BIT - 1);
   assign lastBit  = bitIdx == 3'd7;
   assign lastByte = byteIdx == BW'(NB - 1);
   assign lastWord = wordIdx == AW'(DUMP_WORDS - 1);

   // Non-blocking writes give read-first behaviour for same-cycle read/write
   always_ff @(posedge clk)
      if (writeEn && addrOk)
         for (int i = 0; i < NB; i++)
            if (byteEn[i]) mem[addrIdx][8*i +: 8] <= dataIn[8*i +: 8];

   always_ff @(posedge clk)
      if (rst) dataOut <= '0;
      else if (readEn) dataOut <= addrOk ? mem[addrIdx] : '0;

   always_ff @(posedge clk)
      if (rst) begin
         state  <= IDLE;
         enPrev <= 1'b0;
      end else begin
         state  <= nextState;
         enPrev <= enableUart;
      end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:  nextState = trigger ? LOAD : IDLE;
         LOAD:  nextState = START;
         START: nextState = baudTick ? DATA : START;
         DATA:  nextState = (baudTick && lastBit) ? STOP : DATA;
         STOP:  nextState = !baudTick ? STOP : !lastByte ? START : !lastWord ? LOAD : DONE;
         DONE:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      dataUart = (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : 1'b1;
      uartBusy = state != IDLE;
      uartDone = state == DONE;
   end

   // Shift register is consumed LSB first; after 8 shifts the next byte sits in the low lane
   always_ff @(posedge clk)
      if (rst) begin
         baudCnt <= '0;
         bitIdx  <= '0;
         byteIdx <= '0;
         wordIdx <= '0;
      end else begin
         baudCnt <= ((state == START || state == DATA || state == STOP) && !baudTick) ? baudCnt + 1'b1 : '0;
         if (state == IDLE || state == DONE) wordIdx <= '0;
         if (state == LOAD) begin
            shreg   <= mem[wordIdx];
            byteIdx <= '0;
            bitIdx  <= '0;
         end
         if (state == DATA && baudTick) begin
            shreg  <= shreg >> 1;
            bitIdx <= bitIdx + 1'b1;
         end
         if (state == STOP && baudTick) begin
            byteIdx <= lastByte ? '0 : byteIdx + 1'b1;
            if (lastByte && !lastWord) wordIdx <= wordIdx + 1'b1;
         end
      end
endmodule

// File: tb/tb_data_memory_uart_dump.sv
// tb_data_memory_uart_dump: directed checks of memory port and UART dump
`timescale 1ns/1ps
module tb_data_memory_uart_dump;
   logic        clk = 1'b0;
   logic        rst;
   logic        weA, reA, enA, uartA, busyA, doneA;
   logic [3:0]  beA;
   logic [31:0] addrA, dinA, doutA;
   logic        weB, reB, enB, uartB, busyB, doneB;
   logic [3:0]  beB;
   logic [31:0] addrB, dinB, doutB;
   int          nChecks = 0, nFail = 0;
   logic        samples [2048];
   int          nSamp, doneCnt, doneIdx, cnt;
   logic [31:0] expWords [4];
   logic [9:0]  frame;

   always #5 clk = ~clk;

   data_memory_uart_dump dutA (
      .clk(clk), .rst(rst), .writeEn(weA), .readEn(reA), .byteEn(beA), .address(addrA),
      .dataIn(dinA), .dataOut(doutA), .enableUart(enA), .dataUart(uartA),
      .uartBusy(busyA), .uartDone(doneA));

   data_memory_uart_dump #(.DATA_W(32), .DEPTH(4), .DUMP_WORDS(4), .CLKS_PER_BIT(4)) dutB (
      .clk(clk), .rst(rst), .writeEn(weB), .readEn(reB), .byteEn(beB), .address(addrB),
      .dataIn(dinB), .dataOut(doutB), .enableUart(enB), .dataUart(uartB),
      .uartBusy(busyB), .uartDone(doneB));

   task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic writeA(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk); weA = 1'b1; addrA = a; dinA = d; beA = be;
      @(negedge clk); weA = 1'b0;
   endtask

   task automatic readA(input logic [31:0] a);
      @(negedge clk); reA = 1'b1; addrA = a;
      @(negedge clk); reA = 1'b0;
   endtask

   task automatic writeB(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk); weB = 1'b1; addrB = a; dinB = d; beB = 4'hF;
      @(negedge clk); weB = 1'b0;
   endtask

   task automatic getFrame(input int base, output logic [9:0] f);
      for (int k = 0; k < 10; k++) f[k] = samples[base + k*4 + 2];
   endtask

   initial begin
      rst = 1'b1;
      {weA, reA, enA, beA, addrA, dinA} = '0;
      {weB, reB, enB, beB, addrB, dinB} = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkVal("rstDataOut", doutA, 0);
      checkVal("rstUartLine", uartB, 1);
      checkVal("rstBusy", busyB, 0);
      checkVal("rstDone", doneB, 0);

      // T1
      writeA(2, 32'hAAF00FAA, 4'hF);
      writeA(1, 32'hAEF039A8, 4'hF);
      writeA(0, 32'h00000001, 4'hF);
      readA(2); checkVal("t1rd2", doutA, 32'hAAF00FAA);
      readA(1); checkVal("t1rd1", doutA, 32'hAEF039A8);
      readA(0); checkVal("t1rd0", doutA, 32'h00000001);
      @(negedge clk); addrA = 2;
      @(negedge clk); checkVal("readHold", doutA, 32'h00000001);

      // T2
      writeA(3, 32'h11223344, 4'hF);
      writeA(3, 32'hFFFFFFFF, 4'b0101);
      readA(3); checkVal("t2lanes", doutA, 32'h11FF33FF);

      // T3
      writeA(64, 32'hBADBAD00, 4'hF);
      readA(0); checkVal("t3w0", doutA, 32'h00000001);
      readA(1); checkVal("t3w1", doutA, 32'hAEF039A8);
      readA(2); checkVal("t3w2", doutA, 32'hAAF00FAA);
      readA(3); checkVal("t3w3", doutA, 32'h11FF33FF);
      readA(69); checkVal("t3oob", doutA, 0);

      // T4
      writeA(5, 32'h0, 4'hF);
      readA(2);
      @(negedge clk); weA = 1'b1; reA = 1'b1; addrA = 5; dinA = 32'hCAFEBABE; beA = 4'hF;
      @(negedge clk); weA = 1'b0; reA = 1'b0;
      checkVal("t4readFirst", doutA, 0);
      readA(5); checkVal("t4after", doutA, 32'hCAFEBABE);

      // T5: word 0 is overwritten after its load, word 3 before its load
      writeB(0, 32'h00000001);
      writeB(1, 32'h12345678);
      writeB(2, 32'h800000FE);
      writeB(3, 32'hDEADBEEF);
      expWords = '{32'h00000001, 32'h12345678, 32'h800000FE, 32'h0F0F3C5A};
      @(negedge clk); enB = 1'b1;
      nSamp = 0; doneCnt = 0; doneIdx = -1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (busyB) begin
            samples[nSamp] = uartB;
            if (doneB) begin doneCnt++; doneIdx = nSamp; end
            nSamp++;
         end else if (nSamp > 0) break;
         if (nSamp == 10) begin weB = 1'b1; addrB = 0; dinB = 32'hFFFFFFFF; beB = 4'hF; end
         if (nSamp == 11) begin addrB = 3; dinB = 32'h0F0F3C5A; end
         if (nSamp == 12) weB = 1'b0;
      end
      checkVal("busyCycles", nSamp, 645);
      checkVal("donePulses", doneCnt, 1);
      checkVal("doneLast", doneIdx, 644);
      checkVal("loadIdle", samples[0], 1);
      frame = '0;
      for (int j = 0; j < 40; j++) frame[j/4] = samples[1 + j];
      cnt = 0;
      for (int j = 0; j < 40; j++) if (samples[1 + j] !== frame[j/4]) cnt++;
      checkVal("firstFrameBits", frame, 10'b10_0000_0010);
      checkVal("firstFrameWidth", cnt, 0);
      for (int w = 0; w < 4; w++)
         for (int f = 0; f < 4; f++) begin
            getFrame(w*161 + 1 + f*40, frame);
            checkVal($sformatf("frame%0d_%0d", w, f), frame, {1'b1, expWords[w][8*f +: 8], 1'b0});
         end
      cnt = 0;
      repeat (20) begin @(negedge clk); if (busyB) cnt++; end
      checkVal("noRetrigger", cnt, 0);
      @(negedge clk); reB = 1'b1; addrB = 3;
      @(negedge clk); reB = 1'b0;
      checkVal("cpuWriteDuringDump", doutB, 32'h0F0F3C5A);

      // T6
      enB = 1'b0;
      @(negedge clk); enB = 1'b1;
      nSamp = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (busyB) begin samples[nSamp] = uartB; nSamp++; end
         if (nSamp == 61) break;
      end
      checkVal("reachedFrame2", nSamp, 61);
      rst = 1'b1; enB = 1'b0;
      @(negedge clk);
      checkVal("rstLine", uartB, 1);
      checkVal("rstBusy2", busyB, 0);
      checkVal("rstDataOut2", doutA, 0);
      rst = 1'b0;
      cnt = 0;
      repeat (10) begin @(negedge clk); if (doneB || busyB) cnt++; end
      checkVal("noDoneAfterRst", cnt, 0);
      enB = 1'b1;
      nSamp = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (busyB) begin samples[nSamp] = uartB; nSamp++; end
         if (nSamp == 41) break;
      end
      checkVal("restartLen", nSamp, 41);
      getFrame(1, frame);
      checkVal("restartWord0", frame, {1'b1, 8'hFF, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule
